// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// Default geometry and the per-chunk adder helper.
package alu_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int MAX_W      = 64;

    // Zero-extended add of two MAX_W operands plus carry; MSB is carry-out.
    function automatic logic [MAX_W:0] chunk_sum(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic             cin
    );
        return {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/addsub_segment.sv
// One CHUNK-bit ripple segment of the pipelined adder.
// Also reports the carry into its top bit for overflow detection.
module addsub_segment
    import alu_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    // Chunk add; the top-bit carry-in falls out of sum ^ a ^ b at the MSB.
    always_comb begin
        {o_cout, o_sum} = (CHUNK+1)'(chunk_sum(MAX_W'(i_a), MAX_W'(i_b), i_cin));
        o_cmsb = o_sum[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: WIDTH-bit carry chain split into STAGES segments.
// Global-stall valid/ready handshake; flags resolved in the last stage.
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic             i_sub,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_geom
        $error("pipelined_addsub: WIDTH must be divisible by STAGES");
    end
    if (CHUNK > MAX_W) begin : g_bad_chunk
        $error("pipelined_addsub: CHUNK exceeds MAX_W");
    end

    logic w_adv;

    // Per-stage inputs: index 0 is the port side, k is stage k-1's registers.
    logic             w_pv [STAGES];
    logic [WIDTH-1:0] w_pa [STAGES];
    logic [WIDTH-1:0] w_pb [STAGES];
    logic [WIDTH-1:0] w_ps [STAGES];
    logic             w_pc [STAGES];

    assign w_adv   = !o_valid || i_ready;
    assign o_ready = w_adv;

    assign w_pv[0] = i_valid;
    assign w_pa[0] = i_op_a;
    assign w_pb[0] = i_sub ? ~i_op_b : i_op_b;
    assign w_ps[0] = '0;
    assign w_pc[0] = i_cin ^ i_sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] w_s;
        logic             w_co;
        logic             w_cm;
        logic [WIDTH-1:0] w_ns;

        addsub_segment #(.CHUNK(CHUNK)) u_seg (
            .i_a    (CHUNK'(w_pa[k] >> (k * CHUNK))),
            .i_b    (CHUNK'(w_pb[k] >> (k * CHUNK))),
            .i_cin  (w_pc[k]),
            .o_sum  (w_s),
            .o_cout (w_co),
            .o_cmsb (w_cm)
        );

        assign w_ns = w_ps[k] | (WIDTH'(w_s) << (k * CHUNK));

        if (k < LAST) begin : g_mid
            logic             r_v;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_s;
            logic             r_c;
            logic             w_unused_cm;

            assign w_unused_cm = w_cm;

            // Stage register: partial sum, chunk carry and remaining operands.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_v <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                    r_s <= '0;
                    r_c <= 1'b0;
                end else if (w_adv) begin
                    r_v <= w_pv[k];
                    r_a <= w_pa[k];
                    r_b <= w_pb[k];
                    r_s <= w_ns;
                    r_c <= w_co;
                end
            end

            assign w_pv[k+1] = r_v;
            assign w_pa[k+1] = r_a;
            assign w_pb[k+1] = r_b;
            assign w_ps[k+1] = r_s;
            assign w_pc[k+1] = r_c;
        end else begin : g_out
            // Output register: completed sum plus carry, overflow, zero.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    o_valid <= 1'b0;
                    o_sum   <= '0;
                    o_cout  <= 1'b0;
                    o_ovf   <= 1'b0;
                    o_zero  <= 1'b0;
                end else if (w_adv) begin
                    o_valid <= w_pv[k];
                    o_sum   <= w_ns;
                    o_cout  <= w_co;
                    o_ovf   <= w_cm ^ w_co;
                    o_zero  <= (w_ns == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub with STAGES = 1, 4 and 32.
// Table vectors, a stalled stream against a model, and async reset.
module tb_pipelined_addsub;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] s;
        logic [2:0]  f;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic        rdy4 = 1'b1;

    logic        ordy1, ordy4, ordy32;
    logic        ov1, ov4, ov32;
    logic [31:0] s1, s4, s32;
    logic        co1, co4, co32;
    logic        of1, of4, of32;
    logic        z1, z4, z32;

    int n_cmp = 0;
    int n_mis = 0;

    vec_t tbl [13];
    res_t q [$];

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_s1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(ordy1),
        .i_op_a(op_a), .i_op_b(op_b), .i_sub(sub), .i_cin(cin),
        .o_valid(ov1), .i_ready(1'b1), .o_sum(s1), .o_cout(co1),
        .o_ovf(of1), .o_zero(z1)
    );

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_s4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(ordy4),
        .i_op_a(op_a), .i_op_b(op_b), .i_sub(sub), .i_cin(cin),
        .o_valid(ov4), .i_ready(rdy4), .o_sum(s4), .o_cout(co4),
        .o_ovf(of4), .o_zero(z4)
    );

    pipelined_addsub #(.WIDTH(32), .STAGES(32)) u_s32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(ordy32),
        .i_op_a(op_a), .i_op_b(op_b), .i_sub(sub), .i_cin(cin),
        .o_valid(ov32), .i_ready(1'b1), .o_sum(s32), .o_cout(co32),
        .o_ovf(of32), .o_zero(z32)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: plain wide add, overflow from operand/result signs.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sb, input logic ci);
        logic [31:0] be;
        logic [32:0] w;
        res_t r;
        be = sb ? ~b : b;
        w = {1'b0, a} + {1'b0, be} + {32'd0, ci ^ sb};
        r.s = w[31:0];
        r.f = {w[32], (a[31] == be[31]) && (w[31] != a[31]), w[31:0] == 32'd0};
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int l1, l4, l32;
        logic [31:0] r1, r4, r32;
        logic [2:0] f1, f4, f32;
        logic [2:0] fe;
        l1 = -1; l4 = -1; l32 = -1;
        r1 = '0; r4 = '0; r32 = '0;
        f1 = '0; f4 = '0; f32 = '0;
        @(negedge clk);
        op_a = v.a; op_b = v.b; sub = v.sub; cin = v.cin;
        i_valid = 1'b1;
        rdy4 = 1'b1;
        #1 chk($sformatf("v%0d_ready", idx), {ordy1, ordy4, ordy32}, 3'b111);
        @(posedge clk);
        for (int n = 0; n < 34; n++) begin
            @(negedge clk);
            i_valid = 1'b0;
            if (ov1 && l1 < 0) begin l1 = n; r1 = s1; f1 = {co1, of1, z1}; end
            if (ov4 && l4 < 0) begin l4 = n; r4 = s4; f4 = {co4, of4, z4}; end
            if (ov32 && l32 < 0) begin l32 = n; r32 = s32; f32 = {co32, of32, z32}; end
        end
        fe = {v.co, v.ov, v.z};
        chk($sformatf("v%0d_lat_s1", idx), 64'(l1), 64'(0));
        chk($sformatf("v%0d_lat_s4", idx), 64'(l4), 64'(3));
        chk($sformatf("v%0d_lat_s32", idx), 64'(l32), 64'(31));
        chk($sformatf("v%0d_sum_s1", idx), r1, v.s);
        chk($sformatf("v%0d_sum_s4", idx), r4, v.s);
        chk($sformatf("v%0d_sum_s32", idx), r32, v.s);
        chk($sformatf("v%0d_flags_s1", idx), f1, fe);
        chk($sformatf("v%0d_flags_s4", idx), f4, fe);
        chk($sformatf("v%0d_flags_s32", idx), f32, fe);
    endtask

    task automatic run_stream();
        logic [31:0] sa [8];
        logic [31:0] sbv [8];
        logic        ssub [8];
        logic        scin [8];
        int sent, got;
        logic pstall;
        logic [31:0] psum;
        logic [2:0] pflg;
        res_t e;
        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom;
            sbv[i] = $urandom;
            ssub[i] = 1'($urandom_range(1));
            scin[i] = 1'($urandom_range(1));
        end
        sent = 0; got = 0;
        pstall = 1'b0; psum = '0; pflg = '0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            i_valid = (sent < 8);
            if (sent < 8) begin
                op_a = sa[sent]; op_b = sbv[sent];
                sub = ssub[sent]; cin = scin[sent];
            end
            rdy4 = !(c >= 5 && c <= 7);
            #1;
            chk($sformatf("st_c%0d_ready", c), ordy4, !(ov4 && !rdy4));
            if (pstall) begin
                chk($sformatf("st_c%0d_hold_v", c), ov4, 1'b1);
                chk($sformatf("st_c%0d_hold_s", c), s4, psum);
                chk($sformatf("st_c%0d_hold_f", c), {co4, of4, z4}, pflg);
            end
            if (ov4 && rdy4) begin
                if (q.size() == 0) begin
                    chk($sformatf("st_c%0d_extra", c), 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("st_r%0d_sum", got), s4, e.s);
                    chk($sformatf("st_r%0d_flags", got), {co4, of4, z4}, e.f);
                end
                got++;
            end
            if (i_valid && ordy4) begin
                q.push_back(model(sa[sent], sbv[sent], ssub[sent], scin[sent]));
                sent++;
            end
            pstall = ov4 && !rdy4;
            psum = s4;
            pflg = {co4, of4, z4};
        end
        chk("st_count", 64'(got), 64'(8));
        chk("st_queue_empty", 64'(q.size()), 64'(0));
        @(negedge clk);
        i_valid = 1'b0;
        rdy4 = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{32'h5, 32'h7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{32'h5, 32'h4, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b1, 32'h0001_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0, 1'b0};

        #1;
        chk("rst_valid", {ov1, ov4, ov32}, 3'b000);
        chk("rst_sum", {s1, s4, s32}, 96'h0);
        chk("rst_flags", {co4, of4, z4, co1, of1, z1, co32, of32, z32}, 9'h0);
        chk("rst_ready", {ordy1, ordy4, ordy32}, 3'b111);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(tbl[i], i);

        run_stream();

        for (int n = 0; n < 40; n++) @(negedge clk);
        op_a = tbl[4].a; op_b = tbl[4].b; sub = 1'b0; cin = 1'b0;
        i_valid = 1'b1;
        for (int n = 0; n < 4; n++) @(negedge clk);
        i_valid = 1'b0;
        #2 chk("pre_rst_valid_s4", ov4, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {ov1, ov4, ov32}, 3'b000);
        chk("async_rst_sum_s4", s4, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            chk($sformatf("stale_c%0d", n), {ov1, ov4, ov32}, 3'b000);
        end
        run_vec(tbl[5], 105);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
